// File: rtl/syn_pipe_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Tracks producers in EX and DM to drive operand forwarding, detects
// load-use hazards, converts taken branches into flushes, and sequences
// a syscall halt through a fixed-length drain into a sticky halted state.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal issue; hazards resolved by forwarding or stalls
// ST_DRAIN  | halt requested; no new issue while older work retires
// ST_HALTED | pipeline empty; sticky until reset

module syn_pipe_ctrl #(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [4:0]       id_req_a,
    input  logic             id_use_a,
    input  logic [4:0]       id_req_b,
    input  logic             id_use_b,
    input  logic [4:0]       id_req_w,
    input  logic             id_w_en,
    input  logic             id_is_load,
    input  logic             ex_load_pc,
    input  logic             ex_halt,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DRN_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYC);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic             ex_v_q,   ex_v_d;
    logic [4:0]       ex_reg_q, ex_reg_d;
    logic             ex_ld_q,  ex_ld_d;
    logic             dm_v_q,   dm_v_d;
    logic [4:0]       dm_reg_q, dm_reg_d;
    logic [1:0]       state_q,  state_d;
    logic [DRN_W-1:0] drain_q,  drain_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic hit_ex_a, hit_ex_b, hit_dm_a, hit_dm_b;
    logic load_use;
    logic in_run;

    // Source matching against the scoreboard; register 0 and unused operands never match
    always_comb begin
        hit_ex_a = id_use_a && (id_req_a != 5'd0) && ex_v_q && (ex_reg_q == id_req_a);
        hit_ex_b = id_use_b && (id_req_b != 5'd0) && ex_v_q && (ex_reg_q == id_req_b);
        hit_dm_a = id_use_a && (id_req_a != 5'd0) && dm_v_q && (dm_reg_q == id_req_a);
        hit_dm_b = id_use_b && (id_req_b != 5'd0) && dm_v_q && (dm_reg_q == id_req_b);
        load_use = ex_ld_q && (hit_ex_a || hit_ex_b);
        in_run   = (state_q == ST_RUN);
    end

    // Hazard outputs; the drain and halted states hold issue regardless of hazards
    always_comb begin
        flush  = (state_q != ST_HALTED) && ex_load_pc;
        stall  = in_run ? (load_use && !flush) : 1'b1;
        bubble = stall;
        halted = (state_q == ST_HALTED);

        fwd_a = 2'd0;
        if (hit_ex_a && !ex_ld_q) begin
            fwd_a = 2'd1;
        end else if (hit_dm_a) begin
            fwd_a = 2'd2;
        end

        fwd_b = 2'd0;
        if (hit_ex_b && !ex_ld_q) begin
            fwd_b = 2'd1;
        end else if (hit_dm_b) begin
            fwd_b = 2'd2;
        end

        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end

    // Next-state for scoreboard, halt sequencer and saturating event counters
    always_comb begin
        ex_v_d      = ex_v_q;
        ex_reg_d    = ex_reg_q;
        ex_ld_d     = ex_ld_q;
        dm_v_d      = dm_v_q;
        dm_reg_d    = dm_reg_q;
        state_d     = state_q;
        drain_d     = drain_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (en) begin
            dm_v_d   = ex_v_q;
            dm_reg_d = ex_reg_q;

            if (in_run && !stall && !flush) begin
                ex_v_d   = id_w_en && (id_req_w != 5'd0);
                ex_reg_d = id_req_w;
                ex_ld_d  = id_is_load;
            end else begin
                ex_v_d = 1'b0;
            end

            if (in_run && stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
            if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
                flush_cnt_d = flush_cnt_q + CNT_W'(1);
            end

            case (state_q)
                ST_RUN: begin
                    if (ex_halt) begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // A count of 1 (or a zero-length drain) finishes on this edge
                    if (drain_q <= DRN_W'(1)) begin
                        state_d = ST_HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q - DRN_W'(1);
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q      <= 1'b0;
            ex_reg_q    <= 5'd0;
            ex_ld_q     <= 1'b0;
            dm_v_q      <= 1'b0;
            dm_reg_q    <= 5'd0;
            state_q     <= ST_RUN;
            drain_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_reg_q    <= ex_reg_d;
            ex_ld_q     <= ex_ld_d;
            dm_v_q      <= dm_v_d;
            dm_reg_q    <= dm_reg_d;
            state_q     <= state_d;
            drain_q     <= drain_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_syn_pipe_ctrl.sv
// Bench for syn_pipe_ctrl: directed hazard scenarios plus a randomized run
// compared against an instruction-level model of the pipeline.
// A second instance with 4-bit counters exercises saturation.

module tb_syn_pipe_ctrl;

    localparam int DRAIN = 2;

    logic       clk, rst_n, en;
    logic [4:0] id_req_a, id_req_b, id_req_w;
    logic       id_use_a, id_use_b, id_w_en, id_is_load;
    logic       ex_load_pc, ex_halt;

    logic        stall, bubble, flush, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall, s_bubble, s_flush, s_halted;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    syn_pipe_ctrl #(.CNT_W(16), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .id_req_a(id_req_a), .id_use_a(id_use_a),
        .id_req_b(id_req_b), .id_use_b(id_use_b),
        .id_req_w(id_req_w), .id_w_en(id_w_en), .id_is_load(id_is_load),
        .ex_load_pc(ex_load_pc), .ex_halt(ex_halt),
        .stall(stall), .bubble(bubble), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    syn_pipe_ctrl #(.CNT_W(4), .DRAIN_CYC(DRAIN)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en),
        .id_req_a(id_req_a), .id_use_a(id_use_a),
        .id_req_b(id_req_b), .id_use_b(id_use_b),
        .id_req_w(id_req_w), .id_w_en(id_w_en), .id_is_load(id_is_load),
        .ex_load_pc(ex_load_pc), .ex_halt(ex_halt),
        .stall(s_stall), .bubble(s_bubble), .flush(s_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The two most recently issued instructions that are still ahead of
    // WB, plus the number of enabled edges seen since a halt was accepted.
    logic       p1_v, p1_ld;   // instruction issued one cycle ago (in EX)
    logic [4:0] p1_rd;
    logic       p2_v;          // instruction issued two cycles ago (in DM)
    logic [4:0] p2_rd;
    bit         m_halt_seen;
    int         m_since;
    int         m_stalls, m_flushes;

    task automatic m_clear();
        p1_v = 0; p1_ld = 0; p1_rd = 0;
        p2_v = 0; p2_rd = 0;
        m_halt_seen = 0; m_since = 0;
        m_stalls = 0; m_flushes = 0;
    endtask

    function automatic bit m_halted();
        return m_halt_seen && (m_since >= DRAIN);
    endfunction

    function automatic bit m_reads(input logic [4:0] r, input logic u, input logic [4:0] rd);
        return u && (r != 0) && (r == rd);
    endfunction

    function automatic bit m_load_use();
        return p1_v && p1_ld && (m_reads(id_req_a, id_use_a, p1_rd) || m_reads(id_req_b, id_use_b, p1_rd));
    endfunction

    function automatic bit m_flush();
        return !m_halted() && ex_load_pc;
    endfunction

    function automatic bit m_stall();
        if (m_halt_seen) return 1'b1;
        return m_load_use() && !ex_load_pc;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic u);
        if (p1_v && !p1_ld && m_reads(r, u, p1_rd)) return 2'd1;
        if (p2_v && m_reads(r, u, p2_rd)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit m_fwd_dc(input logic [4:0] r, input logic u);
        return p1_v && p1_ld && m_reads(r, u, p1_rd);
    endfunction

    function automatic int m_sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock edge; the model advances with the inputs present at the edge
    task automatic step();
        bit run, st, fl, issue;
        run   = !m_halt_seen;
        st    = m_stall();
        fl    = m_flush();
        issue = run && !st && !fl && id_w_en && (id_req_w != 0);
        @(posedge clk);
        #1;
        if (en && rst_n) begin
            if (run && st) m_stalls++;
            if (fl) m_flushes++;
            p2_v  = p1_v;
            p2_rd = p1_rd;
            p1_v  = issue;
            p1_rd = id_req_w;
            p1_ld = id_is_load;
            if (m_halt_seen) m_since++;
            else if (ex_halt) begin
                m_halt_seen = 1;
                m_since = 0;
            end
        end
    endtask

    task automatic idle_inputs();
        en = 1; id_req_a = 0; id_use_a = 0; id_req_b = 0; id_use_b = 0;
        id_req_w = 0; id_w_en = 0; id_is_load = 0; ex_load_pc = 0; ex_halt = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        m_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        m_clear();
        ex_load_pc = 1;
        #2;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
        n_tests++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble got=%b exp=0", bubble); end
        n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_tests++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_fail++; $display("FAIL reset_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL reset_flush_follows got=%b exp=1", flush); end
        n_tests++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        ex_load_pc = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_alu_forward();
        do_reset();
        id_w_en = 1; id_req_w = 8; id_is_load = 0;
        step();
        id_w_en = 0; id_req_w = 0; id_use_a = 1; id_req_a = 8;
        #1;
        n_tests++; if (fwd_a !== 2'd1) begin n_fail++; $display("FAIL alu_fwd_ex got=%0d exp=1", fwd_a); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_fwd_nostall got=%b exp=0", stall); end
        step();
        #1;
        n_tests++; if (fwd_a !== 2'd2) begin n_fail++; $display("FAIL alu_fwd_dm got=%0d exp=2", fwd_a); end
        n_tests++; if (fwd_b !== 2'd0) begin n_fail++; $display("FAIL alu_fwd_b_unused got=%0d exp=0", fwd_b); end
    endtask

    task automatic test_load_use();
        do_reset();
        id_w_en = 1; id_req_w = 9; id_is_load = 1;
        step();
        id_w_en = 0; id_req_w = 0; id_is_load = 0; id_use_b = 1; id_req_b = 9;
        #1;
        n_tests++; if (stall !== 1'b1 || bubble !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got=%b/%b exp=1/1", stall, bubble); end
        step();
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release got=%b exp=0", stall); end
        n_tests++; if (fwd_b !== 2'd2) begin n_fail++; $display("FAIL load_use_fwd_b got=%0d exp=2", fwd_b); end
        n_tests++; if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        id_w_en = 1; id_req_w = 0; id_is_load = 1;
        step();
        id_w_en = 0; id_is_load = 0; id_use_a = 1; id_req_a = 0; id_use_b = 1; id_req_b = 0;
        #1;
        n_tests++; if (fwd_a !== 2'd0 || fwd_b !== 2'd0) begin n_fail++; $display("FAIL zero_reg_fwd got=%0d/%0d exp=0/0", fwd_a, fwd_b); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_reg_stall got=%b exp=0", stall); end
    endtask

    task automatic test_branch();
        do_reset();
        id_w_en = 1; id_req_w = 3; id_is_load = 1;
        step();
        // ID holds a load to r5 that reads r3; the branch flushes it
        id_req_w = 5; id_use_a = 1; id_req_a = 3; ex_load_pc = 1;
        #1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL branch_flush got=%b exp=1", flush); end
        n_tests++; if (stall !== 1'b0 || bubble !== 1'b0) begin n_fail++; $display("FAIL branch_nostall got=%b/%b exp=0/0", stall, bubble); end
        step();
        ex_load_pc = 0; id_w_en = 0; id_use_a = 1; id_req_a = 5;
        #1;
        n_tests++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL branch_flush_cnt got=%0d exp=1", flush_cnt); end
        n_tests++; if (stall !== 1'b0 || fwd_a !== 2'd0) begin n_fail++; $display("FAIL branch_ex_cleared stall=%b fwd=%0d exp=0/0", stall, fwd_a); end
    endtask

    task automatic test_halt();
        do_reset();
        ex_halt = 1; ex_load_pc = 1;
        #1;
        n_tests++; if (flush !== 1'b1) begin n_fail++; $display("FAIL halt_with_branch_flush got=%b exp=1", flush); end
        step();
        ex_halt = 0; ex_load_pc = 0;
        for (int i = 0; i < DRAIN; i++) begin
            #1;
            n_tests++; if (stall !== 1'b1 || bubble !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL halt_drain[%0d] stall=%b bubble=%b halted=%b exp=1/1/0", i, stall, bubble, halted); end
            step();
        end
        ex_load_pc = 1; ex_halt = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (halted !== 1'b1 || stall !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL halt_sticky[%0d] halted=%b stall=%b flush=%b exp=1/1/0", i, halted, stall, flush); end
            step();
        end
        n_tests++; if (flush_cnt !== 16'd1) begin n_fail++; $display("FAIL halt_flush_cnt got=%0d exp=1", flush_cnt); end
        #2;
        rst_n = 0;
        m_clear();
        #1;
        n_tests++; if (halted !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL halt_async_reset halted=%b stall=%b exp=0/0", halted, stall); end
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_enable_hold();
        do_reset();
        id_w_en = 1; id_req_w = 6; id_is_load = 1; en = 0;
        step();
        step();
        id_w_en = 0; id_use_a = 1; id_req_a = 6;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL en_hold_no_issue got=%b exp=0", stall); end
        en = 1; id_w_en = 1;
        step();
        id_w_en = 0; en = 0;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL en_hold_stall_visible got=%b exp=1", stall); end
        step();
        step();
        n_tests++; if (stall_cnt !== 16'd0 || stall !== 1'b1) begin n_fail++; $display("FAIL en_hold_frozen cnt=%0d stall=%b exp=0/1", stall_cnt, stall); end
    endtask

    task automatic test_saturation();
        do_reset();
        // lw r9,0(r9) issued repeatedly: every second cycle is a load-use stall
        id_w_en = 1; id_req_w = 9; id_is_load = 1; id_use_a = 1; id_req_a = 9;
        for (int i = 0; i < 41; i++) begin
            step();
            #1;
            n_tests++; if (s_stall_cnt !== 4'(m_sat(m_stalls, 15))) begin n_fail++; $display("FAIL sat_track[%0d] got=%0d exp=%0d", i, s_stall_cnt, m_sat(m_stalls, 15)); end
        end
        n_tests++; if (s_stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold4 got=%0d exp=15", s_stall_cnt); end
        n_tests++; if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_wide got=%0d exp=20", stall_cnt); end
    endtask

    task automatic test_random();
        int fw;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            en         = ($urandom_range(0, 3) != 0);
            id_req_a   = 5'($urandom_range(0, 5));
            id_use_a   = 1'($urandom_range(0, 1));
            id_req_b   = 5'($urandom_range(0, 5));
            id_use_b   = 1'($urandom_range(0, 1));
            id_req_w   = 5'($urandom_range(0, 5));
            id_w_en    = ($urandom_range(0, 3) != 0);
            id_is_load = ($urandom_range(0, 2) == 0);
            ex_load_pc = ($urandom_range(0, 9) == 0);
            ex_halt    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 59) == 0) begin
                rst_n = 0;
                m_clear();
            end else begin
                rst_n = 1;
            end
            #1;
            n_tests++; if (stall !== m_stall() || bubble !== m_stall()) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%b/%b exp=%b", cyc, stall, bubble, m_stall()); end
            n_tests++; if (flush !== m_flush()) begin n_fail++; $display("FAIL rnd_flush cyc=%0d got=%b exp=%b", cyc, flush, m_flush()); end
            n_tests++; if (halted !== m_halted()) begin n_fail++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", cyc, halted, m_halted()); end
            if (!m_fwd_dc(id_req_a, id_use_a)) begin
                fw = m_fwd(id_req_a, id_use_a);
                n_tests++; if (fwd_a !== 2'(fw)) begin n_fail++; $display("FAIL rnd_fwd_a cyc=%0d got=%0d exp=%0d", cyc, fwd_a, fw); end
            end
            if (!m_fwd_dc(id_req_b, id_use_b)) begin
                fw = m_fwd(id_req_b, id_use_b);
                n_tests++; if (fwd_b !== 2'(fw)) begin n_fail++; $display("FAIL rnd_fwd_b cyc=%0d got=%0d exp=%0d", cyc, fwd_b, fw); end
            end
            n_tests++; if (stall_cnt !== 16'(m_sat(m_stalls, 65535)) || flush_cnt !== 16'(m_sat(m_flushes, 65535))) begin n_fail++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, stall_cnt, flush_cnt, m_stalls, m_flushes); end
            n_tests++; if (s_stall_cnt !== 4'(m_sat(m_stalls, 15)) || s_flush_cnt !== 4'(m_sat(m_flushes, 15))) begin n_fail++; $display("FAIL rnd_cnt4 cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, s_stall_cnt, s_flush_cnt, m_sat(m_stalls, 15), m_sat(m_flushes, 15)); end
            step();
        end
        rst_n = 1;
    endtask

    initial begin
        m_clear();
        idle_inputs();
        rst_n = 1;
        #3;
        test_reset();
        test_alu_forward();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_halt();
        test_enable_hold();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/syn_pipe_ctrl.md
SYN_PIPE_CTRL -- requirements
Module: syn_pipe_ctrl

Interface
REQ-001 SHALL have one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-002 SHALL have parameters CNT_W (default 16, width of the perf counters) and DRAIN_CYC (default 2, drain cycles after a halt request).
REQ-003 SHALL have ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- en  in  1  global enable; state advances only when high
- id_req_a  in  5  ID source register A
- id_use_a  in  1  ID reads A
- id_req_b  in  5  ID source register B
- id_use_b  in  1  ID reads B
- id_req_w  in  5  ID destination register
- id_w_en  in  1  ID writes a register
- id_is_load  in  1  ID result comes from data memory
- ex_load_pc  in  1  EX taken jump/branch
- ex_halt  in  1  EX syscall halt
- stall  out  1  hold PC and IF/ID
- bubble  out  1  insert NOP into ID/EX
- flush  out  1  clear IF/ID and ID/EX
- fwd_a  out  2  forward select A: 0 regfile, 1 EX/DM, 2 DM/WB
- fwd_b  out  2  same encoding, operand B
- halted  out  1  pipeline drained after halt
- stall_cnt  out  CNT_W  stall-cycle count
- flush_cnt  out  CNT_W  flush-event count

Function
REQ-004 SHALL keep a scoreboard: slot EX {v, reg, ld} and slot DM {v, reg}, describing the producers currently in EX and DM.
REQ-005 A producer with reg==0 SHALL be treated as invalid; a source with req==0 or use==0 SHALL never match.
REQ-006 fwd_a is combinational: 1 if EX.v, !EX.ld and EX.reg==id_req_a; else 2 if DM.v and DM.reg==id_req_a; else 0. The EX match wins over the DM match. fwd_b is the same for operand B.
REQ-007 Load-use: stall=bubble=1 when a used source matches EX.reg with EX.v and EX.ld; fwd for that operand is then don't-care.
REQ-008 flush = ex_load_pc, combinational; when flush=1, stall and bubble SHALL be 0 (flush wins over load-use).
REQ-009 Regfile write-through is provided by the regfile; producers in WB need no tracking.
REQ-010 On each clk edge with en=1, DM SHALL be loaded from EX ({v, reg}).
REQ-011 On each clk edge with en=1, EX SHALL be loaded with {id_w_en && id_req_w!=0, id_req_w, id_is_load} only when state=RUN, stall=0 and flush=0; otherwise EX.v SHALL be cleared.
REQ-012 With en=0, all state, counters and the FSM SHALL hold; combinational outputs SHALL still reflect the held state.
REQ-013 The FSM SHALL have states RUN, DRAIN and HALTED; the reset state is RUN.
REQ-014 RUN -> DRAIN on an en edge with ex_halt=1; the drain counter is loaded with DRAIN_CYC.
REQ-015 In DRAIN, stall=1 and bubble=1 every cycle; flush still follows ex_load_pc.
REQ-016 In DRAIN, the drain counter decrements on each en edge; DRAIN -> HALTED on the edge where it reaches 0.
REQ-017 In HALTED: halted=1, stall=1, bubble=1; the state is sticky until reset; ex_halt and ex_load_pc are ignored (flush=0).
REQ-018 ex_halt and ex_load_pc high in the same cycle: flush=1 and the transition to DRAIN both occur.
REQ-019 stall_cnt SHALL increment on each en edge with stall=1 and state=RUN; flush_cnt SHALL increment on each en edge with flush=1. Both saturate at all-ones with no wrap.

Reset
REQ-020 On rst_n=0, asynchronously: EX.v=0, DM.v=0, state=RUN, drain counter=0, counters=0.
REQ-021 Consequently, while in reset: stall=0, bubble=0, fwd_a=fwd_b=0, halted=0; flush follows ex_load_pc.
REQ-022 Reset asserted mid-DRAIN or in HALTED SHALL return the block to RUN with an empty scoreboard on the next en edge after release.

Verification
REQ-023 ALU forward: issue a writer of r8 with id_w_en=1, ld=0; next cycle ID reads r8 on A -> fwd_a=1, stall=0; one cycle later the reader of r8 sees fwd_a=2.
REQ-024 Load-use: issue a load to r9, next cycle ID reads r9 on B -> stall=bubble=1 for exactly 1 cycle; then fwd_b=2 and stall_cnt=1.
REQ-025 Zero register: issue a writer of r0, then a reader of r0 -> fwd=0, no stall.
REQ-026 Branch over hazard: a load to r3 sits in EX, ID reads r3, and ex_load_pc=1 -> flush=1, stall=0, flush_cnt=1; next cycle EX.v=0.
REQ-027 Halt: ex_halt pulse with DRAIN_CYC=2 -> stall=1 for 2 cycles, then halted=1 and stays high; rst_n low -> halted=0 immediately.
REQ-028 Saturation: with CNT_W=4, hold a load-use stall for 20 cycles -> stall_cnt=15 and holds at 15.
